phy_rx_framer: RTL and testbench
================================

// Module: phy_rx_framer
// PURPOSE
//  Receive-side framer directly downstream of the PCIe PHY data/control demux output.
//  Consumes the byte stream plus K-char flag and strips STP/END/EDB/COM/SKP symbols.
//  Stores each framed payload in a store-and-forward buffer; presents only complete, good packets.
//  Nullified, truncated, oversize or overflowing packets are discarded by write-pointer rollback.
// PARAMETERS
//  DEPTH    64    payload buffer entries; must be a power of two, >= 4
//  MAX_LEN  32    max payload bytes per packet; longer packets are dropped
// PORTS
//  CLK        in   1  single clock; all logic on rising edge
//  RESET      in   1  synchronous, active-high
//  IN_VALID   in   1  IN_DATA/IN_K qualify this cycle; low = no action, state held
//  IN_DATA    in   8  received byte
//  IN_K       in   1  1 = IN_DATA is a K-character (control), 0 = data byte
//  OUT_READY  in   1  consumer accepts OUT_DATA this cycle
//  OUT_VALID  out  1  OUT_DATA holds a byte of a committed packet
//  OUT_DATA   out  8  payload byte
//  OUT_EOP    out  1  last byte of packet
//  FRAME_ERR  out  1  one-cycle pulse: framing violation, packet dropped
//  NULLIFIED  out  1  one-cycle pulse: EDB received, packet dropped
//  OVERFLOW   out  1  one-cycle pulse: buffer full or MAX_LEN exceeded, packet dropped
// BEHAVIOUR
//  Symbols (IN_K=1): STP=8'hFB, END=8'hFD, EDB=8'hFE, COM=8'hBC, SKP=8'h1C.
//  COM/SKP: ignored in every state, never stored, no state change.
//  Reset: state IDLE; rd/spec/commit pointers 0; pending byte invalid; all outputs 0.
//  FSM IDLE: STP -> PAYLOAD (spec_ptr<=commit_ptr, len<=0); data byte, END or EDB -> FRAME_ERR, stay.
//  FSM PAYLOAD:
//   - data byte: previous pending byte (if any) written with eop=0; new byte becomes pending; len+1.
//   - END: len>=1 -> pending written with eop=1, commit_ptr<=spec_ptr+1, -> IDLE;
//     len==0 -> FRAME_ERR, -> IDLE, nothing committed.
//   - EDB: rollback (spec_ptr<=commit_ptr), NULLIFIED, -> IDLE.
//   - STP: rollback, FRAME_ERR, restart new packet, stay PAYLOAD.
//   - other K: rollback, FRAME_ERR, -> DROP.
//   - byte would make len>MAX_LEN, or write with spec_ptr-rd_ptr==DEPTH: rollback, OVERFLOW, -> DROP.
//  FSM DROP: END/EDB -> IDLE (no pulse); STP -> PAYLOAD; data ignored.
//  Pointers ADDR_W+1 bits (ADDR_W=log2 DEPTH), free-running wrap; full = diff==DEPTH.
//  Output first-word-fall-through: OUT_VALID = (rd_ptr != commit_ptr); OUT_DATA/OUT_EOP from mem[rd_ptr].
//  Pop when OUT_VALID & OUT_READY; rd_ptr+1. Pop frees space same cycle for the full check next cycle.
//  Latency: packet's first byte at OUT the cycle after END is sampled (store-and-forward).
//  Simultaneous END-commit and pop are both honoured. Pulses are mutually exclusive per cycle.
//  Buffer holds several committed packets; committed data is never affected by a later rollback.
// CONFIGURATION
//  Macro PHY_RX_FRAMER_STATS_EN:
//   defined: add outputs PKT_CNT[15:0] (committed packets) and ERR_CNT[15:0] (any of the three
//   pulses); both saturate at 16'hFFFF, cleared by RESET.
//   undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package phy_pkg: K-char constants (STP/END/EDB/COM/SKP), framer state encoding.
//  Sub-module rx_pkt_fifo: DEPTH x 9-bit {eop,data} memory with rd/spec/commit pointers,
//  write/commit/rollback/pop controls, full/valid flags. Framer FSM, len counter and
//  pending-byte register stay in phy_rx_framer.
// TESTING
//  STP, 8'h11, 8'h22, 8'h33, END; OUT_READY=1 -> OUT 11,22,33 on 3 consecutive cycles, OUT_EOP on 33.
//  STP, 8'hAA, SKP, 8'hBB, EDB -> NULLIFIED pulse once, OUT_VALID stays 0, pointers equal.
//  STP, END; then data 8'h55 in IDLE -> two FRAME_ERR pulses, nothing output.
//  OUT_READY=0, DEPTH=64, two 32-byte packets then a third STP+byte -> OVERFLOW; first two intact.
//  MAX_LEN+1 data bytes then END -> OVERFLOW, nothing committed; next good packet passes.
//  RESET asserted mid-PAYLOAD after 5 bytes -> next cycle all outputs 0, later packet frames cleanly.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared PHY receive definitions: K-character codes and framer state encoding.
package phy_pkg;

    localparam logic [7:0] SymStp = 8'hFB;
    localparam logic [7:0] SymEnd = 8'hFD;
    localparam logic [7:0] SymEdb = 8'hFE;
    localparam logic [7:0] SymCom = 8'hBC;
    localparam logic [7:0] SymSkp = 8'h1C;

    typedef enum logic [1:0] {
        StIdle,
        StPayload,
        StDrop
    } framer_state_e;

    // COM and SKP are transparent to the framer in every state.
    function automatic logic is_fill(input logic k, input logic [7:0] data);
        return k && ((data == SymCom) || (data == SymSkp));
    endfunction

endpackage

// File: rtl/rx_pkt_fifo.sv
// Store-and-forward packet buffer: speculative writes become visible only on commit,
// and are discarded by rolling the speculative pointer back to the commit pointer.
module rx_pkt_fifo #(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [8:0]               wr_data,
    input  logic                     commit,
    input  logic                     rollback,
    input  logic                     pop,
    output logic                     valid,
    output logic [8:0]               rd_data,
    output logic [$clog2(DEPTH):0]   used
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [8:0]        mem [DEPTH];
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   spec_ptr_q, spec_ptr_d;
    logic [ADDR_W:0]   commit_ptr_q, commit_ptr_d;
    logic [ADDR_W:0]   spec_wr;

    always_comb begin
        spec_wr      = spec_ptr_q + (wr_en ? (ADDR_W + 1)'(1) : '0);
        spec_ptr_d   = rollback ? commit_ptr_q : spec_wr;
        // Commit includes the byte written in the same cycle (the EOP byte).
        commit_ptr_d = commit ? spec_wr : commit_ptr_q;
        rd_ptr_d     = rd_ptr_q + ((pop && valid) ? (ADDR_W + 1)'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[spec_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            spec_ptr_q   <= '0;
            commit_ptr_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            spec_ptr_q   <= spec_ptr_d;
            commit_ptr_q <= commit_ptr_d;
        end
    end

    assign valid   = (rd_ptr_q != commit_ptr_q);
    assign rd_data = mem[rd_ptr_q[ADDR_W-1:0]];
    assign used    = spec_ptr_q - rd_ptr_q;

endmodule

// File: rtl/phy_rx_framer.sv
// PCIe receive framer: strips framing symbols and forwards only complete, good packets.
// Optional statistics outputs PKT_CNT/ERR_CNT when PHY_RX_FRAMER_STATS_EN is defined.
module phy_rx_framer
    import phy_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_K,
    input  logic        OUT_READY,
    output logic        OUT_VALID,
    output logic [7:0]  OUT_DATA,
    output logic        OUT_EOP,
    output logic        FRAME_ERR,
    output logic        NULLIFIED,
    output logic        OVERFLOW
`ifdef PHY_RX_FRAMER_STATS_EN
    ,
    output logic [15:0] PKT_CNT,
    output logic [15:0] ERR_CNT
`endif
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);

    framer_state_e     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        pend_data_q, pend_data_d;
    logic              pend_vld_q, pend_vld_d;
    logic              ferr_q, ferr_d;
    logic              null_q, null_d;
    logic              ovf_q, ovf_d;

    logic              wr_en;
    logic [8:0]        wr_data;
    logic              commit;
    logic              rollback;
    logic              fifo_valid;
    logic [8:0]        rd_data;
    logic [ADDR_W:0]   used;
    logic [ADDR_W+1:0] occ;
    logic              no_room;

    rx_pkt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RESET),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .commit   (commit),
        .rollback (rollback),
        .pop      (OUT_READY),
        .valid    (fifo_valid),
        .rd_data  (rd_data),
        .used     (used)
    );

    // The pending byte already owns a slot, so a new byte needs room beyond it.
    assign occ     = {1'b0, used} + {{(ADDR_W + 1){1'b0}}, pend_vld_q};
    assign no_room = (occ >= (ADDR_W + 2)'(DEPTH));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pend_data_d = pend_data_q;
        pend_vld_d  = pend_vld_q;
        wr_en       = 1'b0;
        wr_data     = {1'b0, pend_data_q};
        commit      = 1'b0;
        rollback    = 1'b0;
        ferr_d      = 1'b0;
        null_d      = 1'b0;
        ovf_d       = 1'b0;

        if (IN_VALID && !is_fill(IN_K, IN_DATA)) begin
            unique case (state_q)
                StIdle: begin
                    if (IN_K && (IN_DATA == SymStp)) begin
                        state_d    = StPayload;
                        rollback   = 1'b1;
                        len_d      = '0;
                        pend_vld_d = 1'b0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                StPayload: begin
                    if (!IN_K) begin
                        if ((len_q == LEN_W'(MAX_LEN)) || no_room) begin
                            rollback   = 1'b1;
                            ovf_d      = 1'b1;
                            pend_vld_d = 1'b0;
                            state_d    = StDrop;
                        end else begin
                            wr_en       = pend_vld_q;
                            pend_data_d = IN_DATA;
                            pend_vld_d  = 1'b1;
                            len_d       = len_q + LEN_W'(1);
                        end
                    end else begin
                        pend_vld_d = 1'b0;
                        case (IN_DATA)
                            SymEnd: begin
                                state_d = StIdle;
                                if (len_q != '0) begin
                                    wr_en   = 1'b1;
                                    wr_data = {1'b1, pend_data_q};
                                    commit  = 1'b1;
                                end else begin
                                    ferr_d = 1'b1;
                                end
                            end
                            SymEdb: begin
                                rollback = 1'b1;
                                null_d   = 1'b1;
                                state_d  = StIdle;
                            end
                            SymStp: begin
                                rollback = 1'b1;
                                ferr_d   = 1'b1;
                                len_d    = '0;
                            end
                            default: begin
                                rollback = 1'b1;
                                ferr_d   = 1'b1;
                                state_d  = StDrop;
                            end
                        endcase
                    end
                end
                StDrop: begin
                    if (IN_K && ((IN_DATA == SymEnd) || (IN_DATA == SymEdb))) begin
                        state_d = StIdle;
                    end else if (IN_K && (IN_DATA == SymStp)) begin
                        state_d    = StPayload;
                        rollback   = 1'b1;
                        len_d      = '0;
                        pend_vld_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            len_q       <= '0;
            pend_data_q <= '0;
            pend_vld_q  <= 1'b0;
            ferr_q      <= 1'b0;
            null_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pend_data_q <= pend_data_d;
            pend_vld_q  <= pend_vld_d;
            ferr_q      <= ferr_d;
            null_q      <= null_d;
            ovf_q       <= ovf_d;
        end
    end

    assign OUT_VALID = fifo_valid;
    assign OUT_DATA  = fifo_valid ? rd_data[7:0] : 8'h00;
    assign OUT_EOP   = fifo_valid & rd_data[8];
    assign FRAME_ERR = ferr_q;
    assign NULLIFIED = null_q;
    assign OVERFLOW  = ovf_q;

`ifdef PHY_RX_FRAMER_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (commit && (pkt_cnt_q != 16'hFFFF)) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if ((ferr_d || null_d || ovf_d) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign PKT_CNT = pkt_cnt_q;
    assign ERR_CNT = err_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_phy_rx_framer.sv
// Self-checking bench for phy_rx_framer: symbol tables, hand sequences and an output scoreboard.
module tb_phy_rx_framer;

    localparam int DEPTH   = 64;
    localparam int MAX_LEN = 32;

    localparam bit [7:0] STP = 8'hFB;
    localparam bit [7:0] END = 8'hFD;
    localparam bit [7:0] EDB = 8'hFE;
    localparam bit [7:0] COM = 8'hBC;
    localparam bit [7:0] SKP = 8'h1C;
    localparam bit [7:0] BAD = 8'hF7;

    // Expected pulse vector {FRAME_ERR, NULLIFIED, OVERFLOW}.
    localparam bit [2:0] PN = 3'b000;
    localparam bit [2:0] PF = 3'b100;
    localparam bit [2:0] PU = 3'b010;
    localparam bit [2:0] PO = 3'b001;

    typedef struct {
        bit       k;
        bit [7:0] d;
        bit [2:0] p;
        bit       c;
    } vec_t;

    logic       CLK;
    logic       RESET;
    logic       IN_VALID;
    logic [7:0] IN_DATA;
    logic       IN_K;
    logic       OUT_READY;
    logic       OUT_VALID;
    logic [7:0] OUT_DATA;
    logic       OUT_EOP;
    logic       FRAME_ERR;
    logic       NULLIFIED;
    logic       OVERFLOW;

    int         n_vec;
    int         n_err;
    logic [8:0] sb[$];
    logic [7:0] stage[$];
    vec_t       tbl[$];

    phy_rx_framer #(
        .DEPTH   (DEPTH),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_DATA   (IN_DATA),
        .IN_K      (IN_K),
        .OUT_READY (OUT_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .OUT_EOP   (OUT_EOP),
        .FRAME_ERR (FRAME_ERR),
        .NULLIFIED (NULLIFIED),
        .OVERFLOW  (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Called at posedge+1; the symbol is sampled at the next edge and its pulse checked after it.
    task automatic sym(input bit k, input bit [7:0] d, input bit [2:0] p, input bit c);
        IN_VALID = 1'b1;
        IN_K     = k;
        IN_DATA  = d;
        if (k && d == STP) stage.delete();
        else if (!k) stage.push_back(d);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        if (c) begin
            for (int i = 0; i < stage.size(); i++) begin
                sb.push_back({(i == stage.size() - 1), stage[i]});
            end
            stage.delete();
        end
        check($sformatf("pulse k=%0b d=%02h", k, d), {FRAME_ERR, NULLIFIED, OVERFLOW}, p);
    endtask

    task automatic add(input bit k, input bit [7:0] d, input bit [2:0] p, input bit c);
        vec_t v;
        v.k = k;
        v.d = d;
        v.p = p;
        v.c = c;
        tbl.push_back(v);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((sb.size() != 0 || OUT_VALID) && i < 300) begin
            @(posedge CLK);
            #1;
            i++;
        end
        check(name, {31'd0, (sb.size() == 0 && !OUT_VALID)}, 32'd1);
    endtask

    always @(negedge CLK) begin
        logic [8:0] exp;
        if (!RESET && OUT_VALID && OUT_READY) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: got data %02h eop %0b, required no output",
                         OUT_DATA, OUT_EOP);
            end else begin
                exp = sb.pop_front();
                if ({OUT_EOP, OUT_DATA} !== exp) begin
                    n_err++;
                    $display("FAIL out_byte: got eop %0b data %02h, required eop %0b data %02h",
                             OUT_EOP, OUT_DATA, exp[8], exp[7:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        RESET     = 1'b1;
        IN_VALID  = 1'b0;
        IN_K      = 1'b0;
        IN_DATA   = 8'h00;
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outs", {OUT_VALID, OUT_EOP, OUT_DATA, FRAME_ERR, NULLIFIED, OVERFLOW}, 0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Basic packet with explicit first-byte latency and back-to-back output.
        sym(1, STP, PN, 0);
        sym(0, 8'h11, PN, 0);
        sym(0, 8'h22, PN, 0);
        sym(0, 8'h33, PN, 0);
        sym(1, END, PN, 1);
        check("lat_b0", {OUT_VALID, OUT_EOP, OUT_DATA}, {1'b1, 1'b0, 8'h11});
        @(posedge CLK); #1;
        check("lat_b1", {OUT_VALID, OUT_EOP, OUT_DATA}, {1'b1, 1'b0, 8'h22});
        @(posedge CLK); #1;
        check("lat_b2", {OUT_VALID, OUT_EOP, OUT_DATA}, {1'b1, 1'b1, 8'h33});
        @(posedge CLK); #1;
        check("lat_empty", {31'd0, OUT_VALID}, 0);

        // Nullified packet with SKP inside.
        sym(1, STP, PN, 0);
        sym(0, 8'hAA, PN, 0);
        sym(1, SKP, PN, 0);
        sym(0, 8'hBB, PN, 0);
        sym(1, EDB, PU, 0);
        repeat (2) begin
            @(posedge CLK); #1;
            check("null_no_out", {31'd0, OUT_VALID}, 0);
        end

        // Table-driven framing cases.
        add(1, STP, PN, 0); add(1, END, PF, 0); add(0, 8'h55, PF, 0);
        add(1, COM, PN, 0);
        add(1, STP, PN, 0); add(0, 8'h01, PN, 0); add(1, COM, PN, 0);
        add(0, 8'h02, PN, 0); add(1, END, PN, 1);
        add(1, STP, PN, 0); add(0, 8'h10, PN, 0); add(1, STP, PF, 0);
        add(0, 8'h20, PN, 0); add(1, END, PN, 1);
        add(1, STP, PN, 0); add(0, 8'h30, PN, 0); add(1, BAD, PF, 0);
        add(0, 8'h40, PN, 0); add(1, END, PN, 0); add(0, 8'h41, PF, 0);
        add(1, STP, PN, 0); add(0, 8'h50, PN, 0); add(1, BAD, PF, 0);
        add(1, STP, PN, 0); add(0, 8'h60, PN, 0); add(0, 8'h61, PN, 0); add(1, END, PN, 1);
        add(1, END, PF, 0); add(1, EDB, PF, 0);
        add(1, STP, PN, 0); add(0, 8'h77, PN, 0); add(1, END, PN, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            sym(tbl[i].k, tbl[i].d, tbl[i].p, tbl[i].c);
        end
        drain("drain_table");

        // Buffer full: two 32-byte packets held, third packet's first byte overflows.
        OUT_READY = 1'b0;
        sym(1, STP, PN, 0);
        for (int i = 0; i < 32; i++) sym(0, 8'h40 + 8'(i), PN, 0);
        sym(1, END, PN, 1);
        sym(1, STP, PN, 0);
        for (int i = 0; i < 32; i++) sym(0, 8'h80 + 8'(i), PN, 0);
        sym(1, END, PN, 1);
        sym(1, STP, PN, 0);
        sym(0, 8'hEE, PO, 0);
        sym(1, END, PN, 0);
        check("full_head", {OUT_VALID, OUT_EOP, OUT_DATA}, {1'b1, 1'b0, 8'h40});
        OUT_READY = 1'b1;
        drain("drain_full");

        // Length limit: MAX_LEN+1 bytes dropped, exactly MAX_LEN bytes pass.
        sym(1, STP, PN, 0);
        for (int i = 0; i <= MAX_LEN; i++) sym(0, 8'(i), (i == MAX_LEN) ? PO : PN, 0);
        sym(1, END, PN, 0);
        @(posedge CLK); #1;
        check("maxlen_no_out", {31'd0, OUT_VALID}, 0);
        sym(1, STP, PN, 0);
        for (int i = 0; i < MAX_LEN; i++) sym(0, 8'hC0 + 8'(i), PN, 0);
        sym(1, END, PN, 1);
        drain("drain_maxlen");

        // Reset mid-payload with a committed packet still buffered.
        OUT_READY = 1'b0;
        sym(1, STP, PN, 0);
        sym(0, 8'hC1, PN, 0);
        sym(0, 8'hC2, PN, 0);
        sym(1, END, PN, 1);
        sym(1, STP, PN, 0);
        for (int i = 0; i < 5; i++) sym(0, 8'hD0 + 8'(i), PN, 0);
        RESET = 1'b1;
        sb.delete();
        @(posedge CLK); #1;
        check("reset_mid", {OUT_VALID, OUT_EOP, OUT_DATA, FRAME_ERR, NULLIFIED, OVERFLOW}, 0);
        RESET     = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        check("reset_empty", {31'd0, OUT_VALID}, 0);
        sym(1, STP, PN, 0);
        sym(0, 8'h9A, PN, 0);
        sym(0, 8'h9B, PN, 0);
        sym(1, END, PN, 1);
        drain("drain_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
